instr_fetch: RTL

- Instruction fetch/register stage directly downstream of the program memory (pc -> program ROM -> this block).
- Captures each 16-bit word from the ROM and tags it with its pc.
- Assembles AVR two-word instructions (JMP, CALL, LDS, STS) into opcode plus second word.
- Presents the result to the execute stage over a valid/ready handshake, and drives pc_en to tell the pc counter when to advance.

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Bundle between the program ROM, the pc counter, the fetch register and the execute stage.
// Handshake: the instruction fields are valid while ir_valid=1 and hold until a rising
// edge sees ir_valid=1 with ex_ready=1, which is the single transfer point; ex_ready may
// be raised or dropped freely and never affects ir_valid in the same cycle.
interface instr_fetch_if #(
    parameter int PC_WIDTH = 4
);
    logic [PC_WIDTH-1:0] pc_in;
    logic [15:0]         instr_in;
    logic                ex_ready;
    logic                flush;
    logic                pc_en;
    logic [15:0]         ir;
    logic [15:0]         ir_k;
    logic [PC_WIDTH-1:0] ir_pc;
    logic                ir_two_word;
    logic                ir_valid;

    // Fetch stage side: produces the instruction and the pc advance request.
    modport master (
        input  pc_in, instr_in, ex_ready, flush,
        output pc_en, ir, ir_k, ir_pc, ir_two_word, ir_valid
    );

    // ROM / pc counter / execute side.
    modport slave (
        output pc_in, instr_in, ex_ready, flush,
        input  pc_en, ir, ir_k, ir_pc, ir_two_word, ir_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch register: captures ROM words tagged with their pc, joins AVR
// two-word instructions (JMP, CALL, LDS, STS) and hands them to execute.
module instr_fetch #(
    parameter int PC_WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,       // asynchronous, active low
    instr_fetch_if.master   bus,
    output logic            o_dbg_state  // 1 while waiting for the second word
);
    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_ir;
    logic [15:0]         w_ir_next;
    logic [15:0]         r_ir_k;
    logic [15:0]         w_ir_k_next;
    logic [PC_WIDTH-1:0] r_ir_pc;
    logic [PC_WIDTH-1:0] w_ir_pc_next;
    logic                r_two_word;
    logic                w_two_word_next;
    logic                r_valid;
    logic                w_valid_next;
    logic                w_pc_en;
    logic                w_is_two_word;
    logic                w_slot_free;

    // Opcodes whose second ROM word belongs to the same instruction.
    assign w_is_two_word = ((bus.instr_in & 16'hFE0C) == 16'h940C)   // JMP / CALL
                        || ((bus.instr_in & 16'hFE0F) == 16'h9000)   // LDS
                        || ((bus.instr_in & 16'hFE0F) == 16'h9200);  // STS

    // The holding register can take a new word if empty or being consumed now.
    assign w_slot_free = !r_valid || bus.ex_ready;

    // Next-state and pc advance; flush overrides everything except reset.
    always_comb begin
        w_state_next    = r_state;
        w_ir_next       = r_ir;
        w_ir_k_next     = r_ir_k;
        w_ir_pc_next    = r_ir_pc;
        w_two_word_next = r_two_word;
        w_valid_next    = r_valid;
        w_pc_en         = 1'b0;
        if (bus.flush) begin
            w_valid_next    = 1'b0;
            w_two_word_next = 1'b0;
            w_ir_k_next     = 16'h0000;
            w_state_next    = S_FIRST;
        end else if (r_state == S_SECOND) begin
            // ir_valid is low here, so the slot is always free.
            w_pc_en      = 1'b1;
            w_ir_k_next  = bus.instr_in;
            w_valid_next = 1'b1;
            w_state_next = S_FIRST;
        end else if (w_slot_free) begin
            w_pc_en      = 1'b1;
            w_ir_next    = bus.instr_in;
            w_ir_pc_next = bus.pc_in;
            if (w_is_two_word) begin
                w_two_word_next = 1'b1;
                w_valid_next    = 1'b0;
                w_state_next    = S_SECOND;
            end else begin
                w_ir_k_next     = 16'h0000;
                w_two_word_next = 1'b0;
                w_valid_next    = 1'b1;
            end
        end
    end

    // State and instruction registers, cleared to a NOP by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FIRST;
            r_ir       <= 16'h0000;
            r_ir_k     <= 16'h0000;
            r_ir_pc    <= '0;
            r_two_word <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ir       <= w_ir_next;
            r_ir_k     <= w_ir_k_next;
            r_ir_pc    <= w_ir_pc_next;
            r_two_word <= w_two_word_next;
            r_valid    <= w_valid_next;
        end
    end

    // The pc must not move while reset is held, even though the cleared state looks free.
    assign bus.pc_en       = reset & w_pc_en;
    assign bus.ir          = r_ir;
    assign bus.ir_k        = r_ir_k;
    assign bus.ir_pc       = r_ir_pc;
    assign bus.ir_two_word = r_two_word;
    assign bus.ir_valid    = r_valid;
    assign o_dbg_state     = (r_state == S_SECOND);
endmodule
